// File: rtl/button_conditioner_if.sv
// Board-side bundle for the button conditioner: raw keys/switch in, conditioned pulses/level out.
// The master modport drives the raw inputs. The slave modport is the conditioner itself.
interface button_conditioner_if;
  logic key1_raw;
  logic key2_raw;
  logic sw_raw;
  logic button1;
  logic button2;
  logic do_anything;

  modport master (
    output key1_raw, key2_raw, sw_raw,
    input  button1, button2, do_anything
  );

  modport slave (
    input  key1_raw, key2_raw, sw_raw,
    output button1, button2, do_anything
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces two push-buttons and an enable switch.
// Each accepted press becomes a single-cycle pulse, and the switch becomes a clean enable level.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int SYNC_STAGES     = 2,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int SW_ACTIVE_LOW   = 0
) (
  input logic clk,
  input logic rst,
  button_conditioner_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic KEY_INV = 1'(KEY_ACTIVE_LOW != 0);
  localparam logic SW_INV  = 1'(SW_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} keyState_e;

  logic [2:0]                  rawNorm;
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  s;

  keyState_e       keyState_q [2];
  keyState_e       keyState_d [2];
  logic [CW-1:0]   keyCnt_q [2];
  logic [CW-1:0]   keyCnt_d [2];
  logic [1:0]      pulse_q, pulse_d;
  logic            doAny_q, doAny_d;
  logic            swPending_q, swPending_d;
  logic [CW-1:0]   swCnt_q, swCnt_d;

  // Bit order is {sw, key2, key1}. Every bit is normalised so that 1 means pressed/on.
  assign rawNorm = {bus.sw_raw ^ SW_INV, bus.key2_raw ^ KEY_INV, bus.key1_raw ^ KEY_INV};
  assign s       = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= rawNorm;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        keyState_q[k] <= PRESSED;
        keyCnt_q[k]   <= '0;
      end
      pulse_q     <= '0;
      doAny_q     <= 1'b0;
      swPending_q <= 1'b0;
      swCnt_q     <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        keyState_q[k] <= keyState_d[k];
        keyCnt_q[k]   <= keyCnt_d[k];
      end
      pulse_q     <= pulse_d;
      doAny_q     <= doAny_d;
      swPending_q <= swPending_d;
      swCnt_q     <= swCnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      keyState_d[k] = keyState_q[k];
      keyCnt_d[k]   = keyCnt_q[k];
      case (keyState_q[k])
        IDLE: begin
          if (s[k]) begin
            keyState_d[k] = PRESS_WAIT;
            keyCnt_d[k]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[k]) begin
            keyState_d[k] = IDLE;
            keyCnt_d[k]   = '0;
          end else if (keyCnt_q[k] == CNT_LAST) begin
            keyState_d[k] = PRESSED;
            keyCnt_d[k]   = '0;
          end else begin
            keyCnt_d[k] = keyCnt_q[k] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s[k]) begin
            keyState_d[k] = RELEASE_WAIT;
            keyCnt_d[k]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s[k]) begin
            keyState_d[k] = PRESSED;
            keyCnt_d[k]   = '0;
          end else if (keyCnt_q[k] == CNT_LAST) begin
            keyState_d[k] = IDLE;
            keyCnt_d[k]   = '0;
          end else begin
            keyCnt_d[k] = keyCnt_q[k] + CNT_ONE;
          end
        end
        default: begin
          keyState_d[k] = PRESSED;
          keyCnt_d[k]   = '0;
        end
      endcase
    end

    // The first mismatching edge only arms the filter. This gives the switch the same latency as the keys' wait-state entry.
    doAny_d     = doAny_q;
    swPending_d = swPending_q;
    swCnt_d     = swCnt_q;
    if (s[2] == doAny_q) begin
      swPending_d = 1'b0;
      swCnt_d     = '0;
    end else if (!swPending_q) begin
      swPending_d = 1'b1;
      swCnt_d     = '0;
    end else if (swCnt_q == CNT_LAST) begin
      doAny_d     = s[2];
      swPending_d = 1'b0;
      swCnt_d     = '0;
    end else begin
      swCnt_d = swCnt_q + CNT_ONE;
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int k = 0; k < 2; k++) begin
      pulse_d[k] = (keyState_q[k] == PRESS_WAIT) && s[k] && (keyCnt_q[k] == CNT_LAST) && doAny_q;
    end
  end

  assign bus.button1     = pulse_q[0];
  assign bus.button2     = pulse_q[1];
  assign bus.do_anything = doAny_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random key/switch activity.
// Every cycle is compared against a run-length debounce reference model.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES(S),
    .KEY_ACTIVE_LOW(1),
    .SW_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int edgeCount = 0;
  int startEdge = 0;
  int b1Count = 0, b2Count = 0, bothCount = 0;
  int lastB1Edge = -1, lastB2Edge = -1, lastEnEdge = -1;
  bit prevEn = 1'b0;

  // The model is written as a run-length rule: an input's clean level changes once the delayed sample has disagreed for D+1 edges.
  bit pipe [3][S];
  bit level [3];
  int run [3];
  bit expB [2];
  bit expEn;
  bit rawNow [3];
  bit acc [3];
  bit sNow;
  bit oldEn;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, edgeCount);
    end
  endtask

  task automatic applyStimulus(input bit k1, input bit k2, input bit sw, input int cycles);
    @(negedge clk);
    bus.key1_raw = k1;
    bus.key2_raw = k2;
    bus.sw_raw   = sw;
    startEdge    = edgeCount + 1;
    repeat (cycles) @(negedge clk);
  endtask

  always @(posedge clk) edgeCount++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < S; j++) pipe[i][j] = 1'b0;
        run[i] = 0;
      end
      level[0] = 1'b1;
      level[1] = 1'b1;
      level[2] = 1'b0;
      expB[0]  = 1'b0;
      expB[1]  = 1'b0;
      expEn    = 1'b0;
    end else begin
      rawNow[0] = ~bus.key1_raw;
      rawNow[1] = ~bus.key2_raw;
      rawNow[2] = bus.sw_raw;
      oldEn     = level[2];
      for (int i = 0; i < 3; i++) begin
        sNow = pipe[i][S-1];
        for (int j = S - 1; j > 0; j--) pipe[i][j] = pipe[i][j-1];
        pipe[i][0] = rawNow[i];
        acc[i] = 1'b0;
        if (sNow != level[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            level[i] = sNow;
            run[i]   = 0;
            acc[i]   = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      expB[0] = acc[0] && level[0] && oldEn;
      expB[1] = acc[1] && level[1] && oldEn;
      expEn   = level[2];
    end
  end

  always @(negedge clk) begin
    #1;
    checkOutput("button1", 32'(bus.button1), 32'(expB[0]));
    checkOutput("button2", 32'(bus.button2), 32'(expB[1]));
    checkOutput("do_anything", 32'(bus.do_anything), 32'(expEn));
    if (bus.button1 === 1'b1) begin b1Count++; lastB1Edge = edgeCount; end
    if (bus.button2 === 1'b1) begin b2Count++; lastB2Edge = edgeCount; end
    if (bus.button1 === 1'b1 && bus.button2 === 1'b1) bothCount++;
    if (bus.do_anything === 1'b1 && !prevEn) lastEnEdge = edgeCount;
    prevEn = (bus.do_anything === 1'b1);
  end

  initial begin
    int b1Base, b2Base, bothBase;
    bit k1, k2, sw;
    int pick;

    bus.key1_raw = 1'b1;
    bus.key2_raw = 1'b1;
    bus.sw_raw   = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_button1", 32'(bus.button1), 0);
    checkOutput("reset_button2", 32'(bus.button2), 0);
    checkOutput("reset_do_anything", 32'(bus.do_anything), 0);
    rst = 1'b0;

    // Enable latency
    applyStimulus(1, 1, 0, 8);
    b1Base = b1Count; b2Base = b2Count;
    applyStimulus(1, 1, 1, 12);
    checkOutput("enable_latency", 32'(lastEnEdge - startEdge), 6);
    checkOutput("enable_level", 32'(bus.do_anything), 1);
    checkOutput("enable_no_pulse", 32'((b1Count - b1Base) + (b2Count - b2Base)), 0);

    // Clean press of key1
    b1Base = b1Count; b2Base = b2Count;
    applyStimulus(0, 1, 1, 20);
    checkOutput("clean_count", 32'(b1Count - b1Base), 1);
    checkOutput("clean_latency", 32'(lastB1Edge - startEdge), 6);
    checkOutput("clean_b2_quiet", 32'(b2Count - b2Base), 0);
    applyStimulus(1, 1, 1, 10);

    // Bounce on key2, then a stable press
    b2Base = b2Count;
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1, 0, 1, 2);
      applyStimulus(1, 1, 1, 1);
    end
    checkOutput("bounce_no_pulse", 32'(b2Count - b2Base), 0);
    applyStimulus(1, 0, 1, 20);
    checkOutput("bounce_count", 32'(b2Count - b2Base), 1);
    checkOutput("bounce_latency", 32'(lastB2Edge - startEdge), 6);
    applyStimulus(1, 1, 1, 10);

    // Key1 held through a reset pulse
    b1Base = b1Count;
    applyStimulus(0, 1, 1, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("held_reset_no_pulse", 32'(b1Count - b1Base), 0);
    applyStimulus(1, 1, 1, 10);
    applyStimulus(0, 1, 1, 12);
    checkOutput("held_reset_repress", 32'(b1Count - b1Base), 1);
    applyStimulus(1, 1, 1, 10);

    // Press while disabled is lost
    applyStimulus(1, 1, 0, 10);
    checkOutput("disable_level", 32'(bus.do_anything), 0);
    b1Base = b1Count;
    applyStimulus(0, 1, 0, 12);
    applyStimulus(0, 1, 1, 12);
    checkOutput("disabled_press_lost", 32'(b1Count - b1Base), 0);
    applyStimulus(1, 1, 1, 10);
    applyStimulus(0, 1, 1, 12);
    checkOutput("disabled_repress", 32'(b1Count - b1Base), 1);
    applyStimulus(1, 1, 1, 10);

    // Simultaneous press of both keys
    b1Base = b1Count; b2Base = b2Count; bothBase = bothCount;
    applyStimulus(0, 0, 1, 12);
    checkOutput("simul_both", 32'(bothCount - bothBase), 1);
    checkOutput("simul_b1", 32'(b1Count - b1Base), 1);
    checkOutput("simul_b2", 32'(b2Count - b2Base), 1);
    applyStimulus(1, 1, 1, 10);

    // Reset asserted at edge 4 of a press
    b1Base = b1Count;
    applyStimulus(0, 1, 1, 5);
    rst = 1'b1;
    #1;
    checkOutput("midreset_en_drop", 32'(bus.do_anything), 0);
    checkOutput("midreset_b1_zero", 32'(bus.button1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("midreset_no_pulse", 32'(b1Count - b1Base), 0);
    applyStimulus(1, 1, 1, 10);

    // Random activity on all inputs with occasional resets
    k1 = 1'b1; k2 = 1'b1; sw = 1'b1;
    for (int it = 0; it < 250; it++) begin
      pick = int'($urandom_range(0, 12));
      if (pick == 0) begin
        @(negedge clk);
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end else begin
        if (pick <= 4) k1 = ~k1;
        else if (pick <= 8) k2 = ~k2;
        else if (pick <= 10) begin k1 = ~k1; k2 = ~k2; end
        else sw = ~sw;
        applyStimulus(k1, k2, sw, int'($urandom_range(1, 9)));
      end
    end
    applyStimulus(1, 1, 1, 12);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
